// File: rtl/shifter_seq.sv
// shifter_seq: sequential bit-serial shifter, one bit per clock.
// Loads an operand, shifts it left or right by amt positions with a
// programmable fill bit, and reports the shifted-out bits in y.
// Optional feature: define ROTATE_EN to add the rot port; with rot=1 the bit
// leaving x is fed back in, so x rotates instead of shifting.
module shifter_seq #(
    parameter int WIDTH = 8,
    localparam int AW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [AW-1:0]    amt,
    input  logic             dir,
    input  logic             fill,
`ifdef ROTATE_EN
    input  logic             rot,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  x_reg, x_next;
    logic [WIDTH-1:0]  y_reg, y_next;
    logic [AW-1:0]     cnt_reg, cnt_next;
    logic              dir_reg, dir_next;
    logic              fill_reg, fill_next;
`ifdef ROTATE_EN
    logic              rot_reg, rot_next;
`endif

    // Bit entering x on the current shift edge.
    logic              ins;
    // One-step shifted versions of x and y for each direction.
    logic [WIDTH-1:0]  x_shl, x_shr, y_shl, y_shr;

    // Select the inserted bit: the captured fill, or the outgoing bit when rotating.
    always_comb begin
        ins = fill_reg;
`ifdef ROTATE_EN
        if (rot_reg) begin
            ins = dir_reg ? x_reg[0] : x_reg[WIDTH-1];
        end
`endif
    end

    // Per-bit wiring of the single-step left and right shifts.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign x_shl[gi] = ins;
                assign y_shl[gi] = x_reg[WIDTH-1];
            end else begin : g_lsb_n
                assign x_shl[gi] = x_reg[gi-1];
                assign y_shl[gi] = y_reg[gi-1];
            end
            if (gi == WIDTH-1) begin : g_msb
                assign x_shr[gi] = ins;
                assign y_shr[gi] = x_reg[0];
            end else begin : g_msb_n
                assign x_shr[gi] = x_reg[gi+1];
                assign y_shr[gi] = y_reg[gi+1];
            end
        end
    endgenerate

    // Next-state, datapath and status outputs; every target defaulted first.
    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        fill_next  = fill_reg;
`ifdef ROTATE_EN
        rot_next   = rot_reg;
`endif
        busy       = 1'b0;
        done       = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                done = (state_reg == DONE);
                if (start) begin
                    // Accept: snapshot operands so later input changes are harmless.
                    x_next     = a;
                    y_next     = '0;
                    cnt_next   = amt;
                    dir_next   = dir;
                    fill_next  = fill;
`ifdef ROTATE_EN
                    rot_next   = rot;
`endif
                    state_next = (amt == '0) ? DONE : SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                x_next   = dir_reg ? x_shr : x_shl;
                y_next   = dir_reg ? y_shr : y_shl;
                cnt_next = cnt_reg - AW'(1);
                if (cnt_reg == AW'(1)) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
            fill_reg  <= 1'b0;
`ifdef ROTATE_EN
            rot_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
            fill_reg  <= fill_next;
`ifdef ROTATE_EN
            rot_reg   <= rot_next;
`endif
        end
    end

    assign x = x_reg;
    assign y = y_reg;

endmodule

// File: tb/tb_shifter_seq.sv
// tb_shifter_seq: directed vectors for shifter_seq with a result scoreboard.
// Stimulus pushes expected (x, y, done edge) on accept; a negedge monitor
// pops and compares whenever done is presented.
`timescale 1ns/1ps
module tb_shifter_seq;

    localparam int WIDTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [AW-1:0]    amt;
    logic             dir;
    logic             fill;
    logic             rot_drv;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [7:0] ex;
        logic [7:0] ey;
        int         at_edge;
    } exp_t;

    exp_t exp_q[$];

    shifter_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .amt   (amt),
        .dir   (dir),
        .fill  (fill),
`ifdef ROTATE_EN
        .rot   (rot_drv),
`endif
        .busy  (busy),
        .done  (done),
        .x     (x),
        .y     (y)
    );

    always #5 clk = ~clk;

    // Count rising edges so done latency can be checked against the accept edge.
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every done cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_x", 32'(x), 32'(e.ex));
                chk("result_y", 32'(y), 32'(e.ey));
                chk("done_edge", 32'(edge_cnt), 32'(e.at_edge));
            end
        end
    end

    // Present operands with start for one accept edge; optionally register expectation.
    task automatic accept(input logic [7:0] ta, input logic [2:0] tamt, input logic tdir,
                          input logic tfill, input logic trot, input logic [7:0] ex,
                          input logic [7:0] ey, input bit push_exp);
        exp_t e;
        @(negedge clk);
        a = ta; amt = tamt; dir = tdir; fill = tfill; rot_drv = trot; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push_exp) begin
            e.ex = ex; e.ey = ey; e.at_edge = edge_cnt + int'(tamt);
            exp_q.push_back(e);
        end
    endtask

    // Wait (bounded) for done, counting busy cycles, then confirm done is a single pulse.
    task automatic wait_done(input int exp_busy);
        int  busy_cycles;
        bit  seen;
        busy_cycles = 0;
        seen = 1'b0;
        for (int w = 0; w < 2 * WIDTH + 4 && !seen; w++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_cycles", 32'(busy_cycles), 32'(exp_busy));
        @(negedge clk);
        chk("done_pulse_end", 32'(done), 32'd0);
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [2:0] tamt, input logic tdir,
                          input logic tfill, input logic trot, input logic [7:0] ex,
                          input logic [7:0] ey);
        accept(ta, tamt, tdir, tfill, trot, ex, ey, 1'b1);
        wait_done(int'(tamt));
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; start = 1'b0; a = '0; amt = '0; dir = 1'b0; fill = 1'b0; rot_drv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_x", 32'(x), 32'd0);
        chk("reset_y", 32'(y), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        // Left shift, fill 0: B5 << 3
        run_op(8'hB5, 3'd3, 1'b0, 1'b0, 1'b0, 8'hA8, 8'h05);
        // Results hold while idle
        repeat (3) @(negedge clk);
        chk("hold_x", 32'(x), 32'hA8);
        chk("hold_y", 32'(y), 32'h05);

        // Right shift, fill 1: B5 >> 2
        run_op(8'hB5, 3'd2, 1'b1, 1'b1, 1'b0, 8'hED, 8'h40);
        // Right shift, fill 0: B5 >> 3
        run_op(8'hB5, 3'd3, 1'b1, 1'b0, 1'b0, 8'h16, 8'hA0);
        // Left shift max distance, fill 1: 0F << 5
        run_op(8'h0F, 3'd5, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h01);
        // Right shift max distance, fill 1: B5 >> 7
        run_op(8'hB5, 3'd7, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h6A);

        // amt=0 followed by back-to-back accept from DONE
        @(negedge clk);
        a = 8'h3C; amt = 3'd0; dir = 1'b0; fill = 1'b0; rot_drv = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        e.ex = 8'h3C; e.ey = 8'h00; e.at_edge = edge_cnt;
        exp_q.push_back(e);
        a = 8'hB5; amt = 3'd3; dir = 1'b0; fill = 1'b0;
        @(negedge clk);
        chk("amt0_busy", 32'(busy), 32'd0);
        chk("amt0_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        e.ex = 8'hA8; e.ey = 8'h05; e.at_edge = edge_cnt + 3;
        exp_q.push_back(e);
        wait_done(3);

        // amt=7 with a spurious start and operand changes during SHIFT
        accept(8'hB5, 3'd7, 1'b0, 1'b0, 1'b0, 8'h80, 8'h5A, 1'b1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'hFF; amt = 3'd1; dir = 1'b1; fill = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4);

        // Reset in the third SHIFT cycle aborts without done
        accept(8'hB5, 3'd7, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_x", 32'(x), 32'd0);
        chk("abort_y", 32'(y), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (10) @(negedge clk);

        // Reset wins over a simultaneous start
        @(negedge clk);
        a = 8'h3C; amt = 3'd0; start = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_prio_done", 32'(done), 32'd0);
        chk("rst_prio_x", 32'(x), 32'd0);

`ifdef ROTATE_EN
        // Rotation: fill is ignored when rot=1
        run_op(8'h81, 3'd1, 1'b0, 1'b1, 1'b1, 8'h03, 8'h01);
        run_op(8'hB5, 3'd4, 1'b1, 1'b0, 1'b1, 8'h5B, 8'h50);
        // rot=0 still shifts with fill
        run_op(8'h81, 3'd1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h01);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shifter_seq.md
SHIFTER_SEQ -- requirements
Module: shifter_seq

Interface
REQ-001 Parameter WIDTH, default 8: data width; SHALL be a power of two, >= 4.
REQ-002 Localparam AW = $clog2(WIDTH): shift-amount width; maximum shift is WIDTH-1.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only while the block is idle or in DONE.
REQ-006 a  input  WIDTH  operand to be shifted.
REQ-007 amt  input  AW  shift distance, 0..WIDTH-1.
REQ-008 dir  input  1  0 = left shift, 1 = right shift.
REQ-009 fill  input  1  value inserted into each vacated bit position.
REQ-010 rot  input  1  rotate select; present only when ROTATE_EN is defined (see Configuration).
REQ-011 busy  output  1  high while shifting.
REQ-012 done  output  1  one-cycle pulse; x and y are valid from this cycle onward.
REQ-013 x  output  WIDTH  shifted result.
REQ-014 y  output  WIDTH  bits shifted out of x.

Function
REQ-015 States SHALL be IDLE, SHIFT and DONE, with one bit shifted per clock in SHIFT.
REQ-016 Accept: start=1 in IDLE or DONE SHALL load x<=a, y<=0 and cnt<=amt, and capture dir, fill and rot.
- Next state SHALL be DONE if amt==0, else SHIFT.
REQ-017 Each SHIFT edge, left shift SHALL perform x<={x[W-2:0],ins} and y<={y[W-2:0],x[W-1]}; then cnt<=cnt-1.
REQ-018 Each SHIFT edge, right shift SHALL perform x<={ins,x[W-1:1]} and y<={x[0],y[W-1:1]}; then cnt<=cnt-1.
REQ-019 ins SHALL be the captured fill; SHIFT SHALL move to DONE on the edge where cnt goes 1->0.
REQ-020 Final values SHALL satisfy: left, {y,x}=({W'b0,a}<<amt) with fill in the vacated bits; right, {x,y}=({a,W'b0}>>amt) with fill in the vacated bits.
REQ-021 Latency: done SHALL be high in the cycle following the (amt+1)th rising edge, counting the accept edge as the first.
REQ-022 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE, for one cycle.
REQ-023 DONE SHALL return to IDLE when start=0; start=1 in DONE SHALL be accepted back-to-back.
REQ-024 start during SHIFT SHALL be ignored; changes to a, amt, dir, fill or rot after accept SHALL have no effect.
REQ-025 x and y SHALL hold their values in IDLE until the next accept.

Reset
REQ-026 rst=1 at an edge SHALL force state=IDLE and x, y, cnt, busy, done to 0; reset SHALL take priority over start.
REQ-027 Reset during SHIFT SHALL abort the operation with no done pulse.

Configuration
REQ-028 Macro ROTATE_EN: when defined, port rot SHALL exist.
- With rot=1, ins SHALL be the bit leaving x that same edge (x[W-1] for left, x[0] for right), so x rotates; y SHALL capture the bit as in REQ-017/018.
- With rot=0, or with ROTATE_EN undefined (port absent), ins SHALL equal fill.

Verification (WIDTH=8)
REQ-029 a=8'hB5, amt=3, dir=0, fill=0 -> x=8'hA8, y=8'h05, done 4 edges after accept, busy high for 3 cycles.
REQ-030 a=8'hB5, amt=2, dir=1, fill=1 -> x=8'hED, y=8'h40, done 3 edges after accept.
REQ-031 a=8'h3C, amt=0 -> done in the cycle after accept, x=8'h3C, y=8'h00, busy never high; then start held in the DONE cycle -> second operation accepted with no idle gap.
REQ-032 amt=7 run; start pulsed with different a during SHIFT -> ignored, result matches original operands; rst at the 3rd SHIFT cycle -> next cycle x=0, y=0, busy=0, no done.
REQ-033 ROTATE_EN defined, rot=1: a=8'h81, amt=1, dir=0 -> x=8'h03, y=8'h01; a=8'hB5, amt=4, dir=1 -> x=8'h5B, y=8'h50.
